// File: rtl/sclkfifo_unpack.sv
// Unpacks each word read from a first-word-fall-through FIFO into RATIO
// narrower slices and streams them out with a valid/ready handshake.
//
// state   | meaning
// S_EMPTY | no word held, ovalid=0, odata/olast=0
// S_BUSY  | word held, slice cnt_q presented on odata with ovalid=1
module sclkfifo_unpack #(
  parameter int IWIDTH    = 32,
  parameter int RATIO     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                      clk,
  input  logic                      srst,
  output logic                      ren,
  input  logic [IWIDTH-1:0]         rdata,
  input  logic                      rempty,
  output logic                      ovalid,
  input  logic                      oready,
  output logic [IWIDTH/RATIO-1:0]   odata,
  output logic                      olast
);

  localparam int OWIDTH = IWIDTH / RATIO;
  localparam int CW     = $clog2(RATIO);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_BUSY  = 1'b1
  } state_t;

  if (RATIO < 2 || RATIO > 16) begin : g_bad_ratio
    $error("sclkfifo_unpack: RATIO must be in 2..16");
  end
  if (IWIDTH % RATIO != 0) begin : g_bad_width
    $error("sclkfifo_unpack: IWIDTH must be a multiple of RATIO");
  end

  state_t            state_q, state_d;
  logic [IWIDTH-1:0] hold_q, hold_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy;
  logic [31:0]       shamt;

  assign busy   = (state_q == S_BUSY);
  assign ovalid = busy;

  // Slice selection as a right shift keeps the index width independent of IWIDTH.
  always_comb begin
    shamt = '0;
    if (MSB_FIRST) begin
      shamt = 32'((RATIO - 1 - int'(cnt_q)) * OWIDTH);
    end else begin
      shamt = 32'(int'(cnt_q) * OWIDTH);
    end
  end

  always_comb begin
    olast = 1'b0;
    odata = '0;
    if (busy) begin
      olast = (int'(cnt_q) == RATIO - 1);
      odata = OWIDTH'(hold_q >> shamt);
    end
  end

  // Pop when idle, or when the final slice leaves so the next word follows with no bubble.
  assign ren = ~srst & ~rempty & (~busy | (olast & oready));

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    if (ren) begin
      hold_d  = rdata;
      cnt_d   = '0;
      state_d = S_BUSY;
    end else if (busy && oready) begin
      if (olast) begin
        state_d = S_EMPTY;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= S_EMPTY;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sclkfifo_unpack.sv
// Directed bench for sclkfifo_unpack: a queue-based FIFO model feeds two
// instances (MSB-first and LSB-first) and a scoreboard checks every slice.
module tb_sclkfifo_unpack;

  localparam int IW = 32;
  localparam int R  = 4;
  localparam int OW = IW / R;

  logic          clk = 1'b0;
  logic          srst;
  logic          rempty;
  logic          oready;
  logic [IW-1:0] rdata;

  logic          ren_m, ovalid_m, olast_m;
  logic [OW-1:0] odata_m;
  logic          ren_l, ovalid_l, olast_l;
  logic [OW-1:0] odata_l;

  int errors = 0;
  int checks = 0;
  int ren_cnt = 0;

  logic [IW-1:0] fifo[$];
  logic [OW-1:0] exp_m[$];
  logic [OW-1:0] exp_l[$];
  logic          exp_last_m[$];
  logic          exp_last_l[$];

  logic          s_ren, s_ovalid, s_olast;
  logic [OW-1:0] s_odata_m, s_odata_l;

  always #5 clk = ~clk;

  sclkfifo_unpack #(.IWIDTH(IW), .RATIO(R), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .srst(srst), .ren(ren_m), .rdata(rdata), .rempty(rempty),
    .ovalid(ovalid_m), .oready(oready), .odata(odata_m), .olast(olast_m)
  );

  sclkfifo_unpack #(.IWIDTH(IW), .RATIO(R), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .srst(srst), .ren(ren_l), .rdata(rdata), .rempty(rempty),
    .ovalid(ovalid_l), .oready(oready), .odata(odata_l), .olast(olast_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic update_fifo();
    rempty = (fifo.size() == 0);
    rdata  = (fifo.size() == 0) ? '0 : fifo[0];
  endtask

  task automatic expect_word(input logic [IW-1:0] w);
    for (int k = 0; k < R; k++) begin
      exp_m.push_back(w[IW-1-k*OW -: OW]);
      exp_l.push_back(w[k*OW +: OW]);
      exp_last_m.push_back(k == R - 1);
      exp_last_l.push_back(k == R - 1);
    end
  endtask

  task automatic push_word(input logic [IW-1:0] w);
    fifo.push_back(w);
    expect_word(w);
    update_fifo();
  endtask

  // After a reset the held word is gone; only words still in the FIFO will appear.
  task automatic flush_exp();
    exp_m.delete();
    exp_l.delete();
    exp_last_m.delete();
    exp_last_l.delete();
    foreach (fifo[i]) expect_word(fifo[i]);
  endtask

  task automatic step();
    logic do_pop;
    #3;
    s_ren     = ren_m;
    s_ovalid  = ovalid_m;
    s_olast   = olast_m;
    s_odata_m = odata_m;
    s_odata_l = odata_l;
    if (rempty) chk("ren_while_empty", 32'(ren_m), 32'd0);
    if (srst)   chk("ren_during_srst", 32'(ren_m), 32'd0);
    if (!ovalid_m) begin
      chk("idle_odata", 32'(odata_m), 32'd0);
      chk("idle_olast", 32'(olast_m), 32'd0);
    end
    if (ovalid_m && oready) begin
      checks++;
      assert (exp_m.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_slice_msb observed=%0h expected=none", odata_m);
      end
      if (exp_m.size() != 0) begin
        chk("slice_msb", 32'(odata_m), 32'(exp_m.pop_front()));
        chk("olast_msb", 32'(olast_m), 32'(exp_last_m.pop_front()));
      end
    end
    if (ovalid_l && oready) begin
      checks++;
      assert (exp_l.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_slice_lsb observed=%0h expected=none", odata_l);
      end
      if (exp_l.size() != 0) begin
        chk("slice_lsb", 32'(odata_l), 32'(exp_l.pop_front()));
        chk("olast_lsb", 32'(olast_l), 32'(exp_last_l.pop_front()));
      end
    end
    do_pop = ren_m;
    if (ren_m) ren_cnt++;
    @(posedge clk);
    #1;
    if (do_pop && fifo.size() != 0) void'(fifo.pop_front());
    update_fifo();
  endtask

  initial begin
    srst   = 1'b1;
    oready = 1'b1;
    update_fifo();
    @(posedge clk);
    #1;

    // reset holds everything idle even with data waiting
    push_word(32'hAABBCCDD);
    repeat (2) begin
      step();
      chk("reset_ovalid", 32'(s_ovalid), 32'd0);
      chk("reset_ren", 32'(s_ren), 32'd0);
    end
    srst    = 1'b0;
    ren_cnt = 0;

    // single word, both slice orders, one-cycle latency
    step();
    chk("lat_ren_t", 32'(s_ren), 32'd1);
    chk("lat_ovalid_t", 32'(s_ovalid), 32'd0);
    step();
    chk("lat_ovalid_t1", 32'(s_ovalid), 32'd1);
    chk("first_msb", 32'(s_odata_m), 32'h0000_00AA);
    chk("first_lsb", 32'(s_odata_l), 32'h0000_00DD);
    repeat (3) step();
    chk("single_ren_pulse", 32'(ren_cnt), 32'd1);
    step();
    chk("single_drained", 32'(s_ovalid), 32'd0);

    // back-to-back words, no bubble
    push_word(32'h11223344);
    push_word(32'h55667788);
    push_word(32'h99AABBCC);
    step();
    chk("b2b_first_ren", 32'(s_ren), 32'd1);
    for (int i = 0; i < 2 * R; i++) begin
      step();
      chk("b2b_valid", 32'(s_ovalid), 32'd1);
      if (s_olast) chk("b2b_ren_on_last", 32'(s_ren), 32'd1);
    end
    repeat (R) step();
    step();
    chk("b2b_drained", 32'(s_ovalid), 32'd0);

    // backpressure on slice BB
    push_word(32'hAABBCCDD);
    step();
    step();
    oready = 1'b0;
    repeat (3) begin
      step();
      chk("bp_odata", 32'(s_odata_m), 32'h0000_00BB);
      chk("bp_ovalid", 32'(s_ovalid), 32'd1);
      chk("bp_ren", 32'(s_ren), 32'd0);
    end
    oready = 1'b1;
    repeat (3) step();
    step();
    chk("bp_drained", 32'(s_ovalid), 32'd0);

    // underflow protection
    for (int i = 0; i < 20; i++) begin
      step();
      chk("uf_ren", 32'(s_ren), 32'd0);
      chk("uf_ovalid", 32'(s_ovalid), 32'd0);
    end

    // reset right after BB transfers discards CC/DD
    push_word(32'hAABBCCDD);
    push_word(32'h01020304);
    step();
    step();
    step();
    oready = 1'b0;
    srst   = 1'b1;
    step();
    flush_exp();
    srst   = 1'b0;
    oready = 1'b1;
    step();
    chk("rst_ovalid_next", 32'(s_ovalid), 32'd0);
    chk("rst_reload_ren", 32'(s_ren), 32'd1);
    step();
    chk("rst_first_msb", 32'(s_odata_m), 32'h0000_0001);
    chk("rst_first_lsb", 32'(s_odata_l), 32'h0000_0004);
    repeat (3) step();
    step();
    chk("rst_drained", 32'(s_ovalid), 32'd0);

    chk("sb_empty_msb", 32'(exp_m.size()), 32'd0);
    chk("sb_empty_lsb", 32'(exp_l.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
